// File: rtl/ledpanel_pkg.sv
// Shared types and width helpers for the HUB75 binary-code-modulation panel driver.
package ledpanel_pkg;

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_BLANK = 2'd1,
    ST_LATCH = 2'd2,
    ST_ON    = 2'd3
  } state_t;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Pixel words are packed {R,G,B}, so red sits in the most significant slice.
  function automatic int chan_off(input int depth, input int ch);
    return (2 - ch) * depth;
  endfunction

  // Widths never collapse to zero, so single-row or single-plane builds still elaborate.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ledpanel_bcm_timer.sv
// ON-time generator: t = ((BASE_ON << plane) * (brightness + 1)) >> 8, loaded at ON entry and counted down.
module ledpanel_bcm_timer
  import ledpanel_pkg::*;
#(
  parameter int BASE_ON     = 8,
  parameter int COLOR_DEPTH = 8,
  localparam int PLANE_W    = clog2_min1(COLOR_DEPTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               run,
  input  logic [PLANE_W-1:0] plane,
  input  logic [7:0]         brightness,
  output logic               zero,
  output logic               done
);

  localparam int BASE_ON_W = clog2_min1(BASE_ON + 1);
  localparam int T_W       = BASE_ON_W + COLOR_DEPTH + 9;

  logic [T_W-1:0] scaled;
  logic [T_W-1:0] t;
  logic [T_W-1:0] remaining;

  // Full-width product: the shift by 8 is the only place precision is dropped.
  assign scaled = (T_W'(BASE_ON) << plane) * (T_W'(brightness) + T_W'(1));
  assign t      = scaled >> 8;
  assign zero   = (t == '0);
  assign done   = (remaining == T_W'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= t;
    end else if (run && remaining != '0) begin
      remaining <= remaining - T_W'(1);
    end
  end

endmodule

// File: rtl/ledpanel_bcm_driver.sv
// HUB75 BCM scan driver: rows outer, bit-planes inner, SHIFT->BLANK->LATCH->ON per plane.
// Optional double-buffered bank swap at frame wrap is enabled by defining LEDPANEL_DOUBLE_BUF_EN.
module ledpanel_bcm_driver
  import ledpanel_pkg::*;
#(
  parameter int PANEL_W     = 64,
  parameter int PANEL_H     = 64,
  parameter int CHAINED     = 2,
  parameter int COLOR_DEPTH = 8,
  parameter int RD_LATENCY  = 2,
  parameter int BASE_ON     = 8,
  parameter int BLANK_CYC   = 4,
  localparam int COLS       = PANEL_W * CHAINED,
  localparam int SCAN       = PANEL_H / 2,
  localparam int ROW_BITS   = clog2_min1(SCAN),
  localparam int COL_BITS   = clog2_min1(COLS),
  localparam int ADDR_W     = 1 + ROW_BITS + COL_BITS,
  localparam int DATA_W     = 3 * COLOR_DEPTH
) (
  input  logic                display_clock,
  input  logic                display_resetn,
  input  logic [7:0]          brightness,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                front_bank,
  output logic                frame_start,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data_top,
  input  logic [DATA_W-1:0]   rd_data_bot,
  output logic                panel_r0,
  output logic                panel_g0,
  output logic                panel_b0,
  output logic                panel_r1,
  output logic                panel_g1,
  output logic                panel_b1,
  output logic [ROW_BITS-1:0] panel_addr,
  output logic                panel_clk,
  output logic                panel_stb,
  output logic                panel_oe,
  output state_t              fsm_state
);

  localparam int PLANE_W = clog2_min1(COLOR_DEPTH);
  localparam int CNT_W   = clog2_min1(2 * COLS + RD_LATENCY + BLANK_CYC + 2);
  localparam int R_OFF   = chan_off(COLOR_DEPTH, CH_R);
  localparam int G_OFF   = chan_off(COLOR_DEPTH, CH_G);
  localparam int B_OFF   = chan_off(COLOR_DEPTH, CH_B);

  localparam logic [CNT_W-1:0]    SHIFT_LAST = CNT_W'(2 * COLS + RD_LATENCY);
  localparam logic [CNT_W-1:0]    READ_END   = CNT_W'(2 * COLS);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(SCAN - 1);
  localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(COLOR_DEPTH - 1);

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [ROW_BITS-1:0] row;
  logic [PLANE_W-1:0]  plane;
  logic                bank;
  logic                swap_now;
  logic                advance;
  logic                wrap;
  logic                take_swap;
  logic                tmr_load;
  logic                tmr_zero;
  logic                tmr_done;

  logic                rd_en_d, stb_d, oe_d, frame_start_d, swap_ack_d, front_bank_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [ROW_BITS-1:0] addr_d;

  logic [RD_LATENCY-1:0]  vld;
  logic                   hold;
  logic [COLOR_DEPTH-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;

  assign fsm_state = state;
  assign wrap      = advance && (plane == PLANE_LAST) && (row == ROW_LAST);

  // swap_req is a level held by the requester until swap_ack; it is only honoured at frame wrap.
`ifdef LEDPANEL_DOUBLE_BUF_EN
  assign take_swap = wrap && swap_req;
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign take_swap       = 1'b0;
`endif

  ledpanel_bcm_timer #(
    .BASE_ON     (BASE_ON),
    .COLOR_DEPTH (COLOR_DEPTH)
  ) u_timer (
    .clk        (display_clock),
    .resetn     (display_resetn),
    .load       (tmr_load),
    .run        (state == ST_ON),
    .plane      (plane),
    .brightness (brightness),
    .zero       (tmr_zero),
    .done       (tmr_done)
  );

  always_ff @(posedge display_clock) begin
    if (!display_resetn) begin
      state    <= ST_SHIFT;
      cnt      <= '0;
      row      <= '0;
      plane    <= '0;
      bank     <= 1'b0;
      swap_now <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= (next_state != state) ? '0 : cnt + 1'b1;
      swap_now <= take_swap;
      bank     <= bank ^ take_swap;
      if (advance) begin
        if (plane == PLANE_LAST) begin
          plane <= '0;
          row   <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end

  // A zero-length ON period goes straight from LATCH to the next plane's SHIFT.
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    tmr_load   = 1'b0;
    unique case (state)
      ST_SHIFT: if (cnt == SHIFT_LAST) next_state = ST_BLANK;
      ST_BLANK: if (cnt == BLANK_LAST) next_state = ST_LATCH;
      ST_LATCH: begin
        tmr_load = 1'b1;
        if (tmr_zero) begin
          next_state = ST_SHIFT;
          advance    = 1'b1;
        end else begin
          next_state = ST_ON;
        end
      end
      ST_ON: begin
        if (tmr_done) begin
          next_state = ST_SHIFT;
          advance    = 1'b1;
        end
      end
      default: next_state = ST_SHIFT;
    endcase
  end

  always_comb begin
    rd_en_d       = (state == ST_SHIFT) && (cnt < READ_END) && !cnt[0];
    rd_addr_d     = rd_en_d ? {bank, row, cnt[COL_BITS:1]} : rd_addr;
    stb_d         = (state == ST_LATCH);
    oe_d          = (state != ST_ON);
    addr_d        = (state == ST_BLANK) ? row : panel_addr;
    frame_start_d = (state == ST_SHIFT) && (cnt == '0) && (row == '0) && (plane == '0);
    swap_ack_d    = swap_now;
    front_bank_d  = bank;
  end

  assign top_r = rd_data_top[R_OFF +: COLOR_DEPTH];
  assign top_g = rd_data_top[G_OFF +: COLOR_DEPTH];
  assign top_b = rd_data_top[B_OFF +: COLOR_DEPTH];
  assign bot_r = rd_data_bot[R_OFF +: COLOR_DEPTH];
  assign bot_g = rd_data_bot[G_OFF +: COLOR_DEPTH];
  assign bot_b = rd_data_bot[B_OFF +: COLOR_DEPTH];

  // vld tracks when the framebuffer word for an issued read is on rd_data; each word is shown
  // with panel_clk low for one cycle, then held with panel_clk high for one cycle.
  always_ff @(posedge display_clock) begin
    if (!display_resetn) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      panel_stb   <= 1'b0;
      panel_oe    <= 1'b1;
      panel_addr  <= '0;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      front_bank  <= 1'b0;
      vld         <= '0;
      hold        <= 1'b0;
      panel_clk   <= 1'b0;
      {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} <= 6'd0;
    end else begin
      rd_en       <= rd_en_d;
      rd_addr     <= rd_addr_d;
      panel_stb   <= stb_d;
      panel_oe    <= oe_d;
      panel_addr  <= addr_d;
      frame_start <= frame_start_d;
      swap_ack    <= swap_ack_d;
      front_bank  <= front_bank_d;
      vld         <= RD_LATENCY'({vld, rd_en});
      if (vld[RD_LATENCY-1]) begin
        panel_r0  <= top_r[plane];
        panel_g0  <= top_g[plane];
        panel_b0  <= top_b[plane];
        panel_r1  <= bot_r[plane];
        panel_g1  <= bot_g[plane];
        panel_b1  <= bot_b[plane];
        panel_clk <= 1'b0;
        hold      <= 1'b1;
      end else if (hold) begin
        panel_clk <= 1'b1;
        hold      <= 1'b0;
      end else begin
        panel_clk <= 1'b0;
        {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} <= 6'd0;
      end
    end
  end

endmodule
